bf_exec_ctrl: RTL
=================

# bf_exec_ctrl

Execution sequencer for the BFCore. It owns the data tape pointer and fetches each opcode from the synchronous program ROM and the current cell from the synchronous tape RAM. It then pulses the core's `enable` for exactly one cycle, writes the core's result back to the tape, and forwards `.` output bytes over a valid/ready stream. It sits between the core, the program ROM, the tape RAM and the UART TX.

## Interface
Parameters:
- `ram_addr_width`, 8: tape address width; must match the core.
- `data_bit_width`, 8: cell width; must match the core.
- `rom_addr_width`, 10: program address width; must match the core.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  stop request; honoured at the next instruction boundary.
- `prog_len`  in  rom_addr_width  program length; execution ends when the core PC equals this value.
- `busy`  out  1  high in FETCH/EXEC/WB/OUT.
- `done`  out  1  sticky high in DONE.
- `aborted`  out  1  sticky; set when DONE was reached via `abort`.
- `step_count`  out  32  executed instructions, i.e. EXEC cycles; saturates at 32'hFFFF_FFFF.
- `core_enable`  out  1  core enable.
- `core_opcode`  out  3  opcode presented to the core.
- `core_ram_addr`  out  ram_addr_width  tape pointer presented to the core.
- `core_ram_val`  out  data_bit_width  cell value presented to the core.
- `core_next_ram_addr`  in  ram_addr_width  core result: pointer.
- `core_next_ram_val`  in  data_bit_width  core result: cell value.
- `core_cout`  in  1  core result: output strobe.
- `core_rom_addr`  in  rom_addr_width  core PC.
- `rom_addr`  out  rom_addr_width  program ROM read address.
- `rom_data`  in  3  program ROM data; 1-cycle read latency.
- `ram_rd_addr`  out  ram_addr_width  tape read address.
- `ram_rd_data`  in  data_bit_width  tape read data; 1-cycle read latency.
- `ram_we`  out  1  tape write enable.
- `ram_wr_addr`  out  ram_addr_width  tape write address.
- `ram_wr_data`  out  data_bit_width  tape write data.
- `out_valid`  out  1  output byte valid.
- `out_data`  out  data_bit_width  output byte.
- `out_ready`  in  1  output byte accepted.

## Operation
- Internal state:
  - `ptr` register holds the tape pointer.
  - State machine states are IDLE, FETCH, EXEC, WB, OUT, DONE.
- IDLE:
  - `start` with `core_rom_addr == prog_len` goes to DONE.
  - Otherwise `start` goes to FETCH with `ptr` = 0.
- FETCH:
  - Drives `rom_addr` = `core_rom_addr` and `ram_rd_addr` = `ptr`.
  - Always goes to EXEC.
- EXEC:
  - `core_enable` = 1, `core_opcode` = `rom_data`, `core_ram_addr` = `ptr`, `core_ram_val` = `ram_rd_data`.
  - Increments `step_count`.
  - Always goes to WB.
- WB:
  - `ram_we` = 1, `ram_wr_addr` = `core_next_ram_addr`, `ram_wr_data` = `core_next_ram_val`.
  - Updates `ptr` <= `core_next_ram_addr`.
  - If `core_cout`, captures `out_data` <= `core_next_ram_val` and goes to OUT.
  - Otherwise the boundary check applies.
- OUT:
  - `out_valid` is held high with `out_data` stable until `out_valid && out_ready`.
  - Then the boundary check applies.
- Boundary check, in priority order:
  1. `abort` goes to DONE and sets `aborted`.
  2. `core_rom_addr == prog_len` goes to DONE.
  3. Otherwise go to FETCH.
- DONE: holds until `rst`. The core has no reset, so a new run requires `rst` plus core reinitialisation.
- During core skip-forward (`[` on a zero cell), the core only advances the PC and holds its outputs. The resulting WB rewrite of an unchanged cell is harmless and is required behaviour.
- The pointer wraps modulo 2^ram_addr_width; there is no bounds error.
- `core_enable` is 0 in every state except EXEC. `ram_we` is 0 except in WB.

## Timing
- Reset values:
  - State is IDLE and `ptr` = 0.
  - All outputs are 0: `busy`, `done`, `aborted`, `step_count`, `core_enable`, `core_opcode`, `core_ram_addr`, `core_ram_val`, `rom_addr`, `ram_rd_addr`, `ram_we`, `ram_wr_addr`, `ram_wr_data`, `out_valid`, `out_data`.
- Instruction cost:
  - A non-output instruction takes 3 cycles (FETCH, EXEC, WB).
  - An output instruction takes 4 cycles plus one cycle for each cycle `out_ready` is low.
- `start` to first `core_enable`: 2 cycles. `done` rises 1 cycle after the final WB or OUT handshake.
- `abort` raised mid-instruction completes the current instruction, including the OUT handshake; it is never taken between EXEC and WB.
- Reset asserted mid-operation:
  - All outputs clear immediately (asynchronous reset).
  - A pending `out_valid` drops without a handshake.
  - An in-progress tape write is lost.

## Test plan
- `prog_len` = 0, pulse `start` -> DONE 1 cycle later; `step_count` = 0, no `core_enable` pulse.
- Program `+++.`, `out_ready` tied high -> one output byte 8'h03; `step_count` = 4; cell 0 = 3; `done` asserts 14 cycles after `start`.
- Program `>>-.`, `out_ready` low for 5 cycles in OUT -> `out_data` = 8'hFF held stable for all 5 stall cycles; pointer = 2; `ram_wr_addr` = 2 on the `-` write.
- Program `<+`, starting pointer 0 -> pointer wraps to 8'hFF; cell 8'hFF = 1.
- Program `++[->+<]>.` -> output 8'h02; cell 0 = 0; correct loop exit with no spurious `out_valid`.
- Program `[+.]` with cell 0 = 0 (skip path) -> no output; DONE reached; `step_count` = 4; assert `abort` during a long loop -> DONE with `aborted` = 1 after the current WB.

Source files
------------

// File: rtl/bf_exec_ctrl.sv
// Execution sequencer for BFCore: fetches opcode and cell, pulses the core for one
// cycle, writes the result back to the tape and forwards '.' bytes over valid/ready.
module bf_exec_ctrl #(
  parameter int unsigned ram_addr_width = 8,
  parameter int unsigned data_bit_width = 8,
  parameter int unsigned rom_addr_width = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [rom_addr_width-1:0] prog_len,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic [31:0]               step_count,
  output logic                      core_enable,
  output logic [2:0]                core_opcode,
  output logic [ram_addr_width-1:0] core_ram_addr,
  output logic [data_bit_width-1:0] core_ram_val,
  input  logic [ram_addr_width-1:0] core_next_ram_addr,
  input  logic [data_bit_width-1:0] core_next_ram_val,
  input  logic                      core_cout,
  input  logic [rom_addr_width-1:0] core_rom_addr,
  output logic [rom_addr_width-1:0] rom_addr,
  input  logic [2:0]                rom_data,
  output logic [ram_addr_width-1:0] ram_rd_addr,
  input  logic [data_bit_width-1:0] ram_rd_data,
  output logic                      ram_we,
  output logic [ram_addr_width-1:0] ram_wr_addr,
  output logic [data_bit_width-1:0] ram_wr_data,
  output logic                      out_valid,
  output logic [data_bit_width-1:0] out_data,
  input  logic                      out_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                    state_q, state_d, boundary_state;
  logic [ram_addr_width-1:0] ptr_q, ptr_d;
  logic [data_bit_width-1:0] out_data_q, out_data_d;
  logic [31:0]               step_q, step_d;
  logic                      aborted_q, aborted_d;
  logic                      at_end;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      out_data_q <= '0;
      step_q     <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      step_q     <= step_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next state and per-state memory/core/stream strobes
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    out_data_d     = out_data_q;
    step_d         = step_q;
    aborted_d      = aborted_q;
    busy           = 1'b0;
    core_enable    = 1'b0;
    core_opcode    = '0;
    core_ram_addr  = '0;
    core_ram_val   = '0;
    rom_addr       = '0;
    ram_rd_addr    = '0;
    ram_we         = 1'b0;
    ram_wr_addr    = '0;
    ram_wr_data    = '0;
    out_valid      = 1'b0;
    at_end         = (core_rom_addr == prog_len);
    boundary_state = S_FETCH;

    // Instruction boundary: abort wins over normal program end
    if (abort || at_end) boundary_state = S_DONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = '0;
          state_d = at_end ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy        = 1'b1;
        rom_addr    = core_rom_addr;
        ram_rd_addr = ptr_q;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        busy          = 1'b1;
        core_enable   = 1'b1;
        core_opcode   = rom_data;
        core_ram_addr = ptr_q;
        core_ram_val  = ram_rd_data;
        if (step_q != 32'hFFFF_FFFF) step_d = step_q + 32'd1;
        state_d       = S_WB;
      end
      S_WB: begin
        busy        = 1'b1;
        ram_we      = 1'b1;
        ram_wr_addr = core_next_ram_addr;
        ram_wr_data = core_next_ram_val;
        ptr_d       = core_next_ram_addr;
        if (core_cout) begin
          out_data_d = core_next_ram_val;
          state_d    = S_OUT;
        end else begin
          state_d = boundary_state;
          if (abort) aborted_d = 1'b1;
        end
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = boundary_state;
          if (abort) aborted_d = 1'b1;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done       = (state_q == S_DONE);
  assign aborted    = aborted_q;
  assign step_count = step_q;
  assign out_data   = out_data_q;

endmodule
